rr_mux: RTL and testbench

//   N-input to 1-output stream multiplexer with round-robin arbitration.
//   It combines N valid/ready streams into one. This is the merge-side counterpart of the DMux split path.
//   A single registered output stage gives 1-cycle latency and full throughput.
//   It sits between producer blocks and a shared consumer, for example a shared bus or a memory write port.
//

---
 rtl/rr_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/rr_mux.sv | 149 ++++++++++++++
 tb/tb_rr_mux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// Shared helpers for the round-robin stream mux.
//   rr_selw : index width for an N-way select (at least 1 bit)
//   rr_next : wrap-around increment of a round-robin pointer
package rr_pkg;

  function automatic int unsigned rr_selw(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority pick.
// Ports:
//   req_i        : request vector, one bit per stream
//   ptr_i        : highest-priority stream index this cycle
//   gnt_c_o      : one-hot grant (zero when nothing requests)
//   gnt_idx_c_o  : index of the granted stream
//   any_c_o      : at least one request present
module rr_arbiter
  import rr_pkg::*;
#(
  parameter  int unsigned N    = 2,
  localparam int unsigned SELW = rr_selw(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    gnt_c_o,
  output logic [SELW-1:0] gnt_idx_c_o,
  output logic            any_c_o
);

  localparam int unsigned W2 = 2 * N;

  logic [W2-1:0] req2_c;
  logic [W2-1:0] masked_c;

  // Upper copy holds the wrapped requests; lower copy is masked below ptr,
  // so the lowest set bit of the masked vector is the round-robin winner.
  always_comb begin
    req2_c      = {req_i, req_i};
    masked_c    = req2_c & ~((W2'(1) << ptr_i) - W2'(1));
    gnt_idx_c_o = '0;
    any_c_o     = 1'b0;
    for (int i = int'(W2) - 1; i >= 0; i--) begin
      if (masked_c[i]) begin
        any_c_o     = 1'b1;
        gnt_idx_c_o = (i >= int'(N)) ? SELW'(i - int'(N)) : SELW'(i);
      end
    end
    gnt_c_o = any_c_o ? (N'(1) << gnt_idx_c_o) : '0;
  end

endmodule

// File: rtl/rr_mux.sv
// N-to-1 valid/ready stream mux with round-robin arbitration and a single
// registered output stage (1-cycle latency, 1 beat/cycle throughput).
// Optional packet lock: define RR_MUX_LOCK_EN to hold the grant on one
// stream from its first beat until the beat carrying in_last.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   in_data    : packed input data, stream i at [i*WIDTH +: WIDTH]
//   in_valid   : per-stream beat offered
//   in_last    : per-stream end-of-packet marker
//   in_ready   : per-stream accept (one-hot or zero, combinational)
//   out_data   : registered output data
//   out_sel    : index of the stream that produced out_data
//   out_last   : registered in_last of the accepted beat
//   out_valid  : output register holds a beat
//   out_ready  : consumer accepts the output beat
module rr_mux
  import rr_pkg::*;
#(
  parameter  int unsigned N     = 2,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SELW  = rr_selw(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [N-1:0]     req_c;
  logic [N-1:0]     gnt_c;
  logic [SELW-1:0]  gnt_idx_c;
  logic             any_c;
  logic             load_c;
  logic             xfer_c;
  logic [WIDTH-1:0] data_mux_c;
  logic             last_mux_c;

`ifdef RR_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SELW-1:0]  lockid_q, lockid_d;

  // While a packet is open only its owner may be granted.
  assign req_c = lock_q ? (in_valid & (N'(1) << lockid_q)) : in_valid;
`else
  assign req_c = in_valid;
`endif

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req_i       (req_c),
    .ptr_i       (ptr_q),
    .gnt_c_o     (gnt_c),
    .gnt_idx_c_o (gnt_idx_c),
    .any_c_o     (any_c)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign load_c   = ~out_valid_q | out_ready;
  assign xfer_c   = load_c & any_c & ~reset;
  assign in_ready = xfer_c ? gnt_c : '0;

  // One-hot select of the granted stream's payload.
  always_comb begin
    data_mux_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_c[i]) data_mux_c = data_mux_c | in_data[i*WIDTH +: WIDTH];
    end
    last_mux_c = |(gnt_c & in_last);
  end

  // Next-state: hold by default, load on accept, empty on idle load.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
`ifdef RR_MUX_LOCK_EN
    lock_d      = lock_q;
    lockid_d    = lockid_q;
`endif
    if (load_c) begin
      if (any_c) begin
        out_data_d  = data_mux_c;
        out_sel_d   = gnt_idx_c;
        out_last_d  = last_mux_c;
        out_valid_d = 1'b1;
`ifdef RR_MUX_LOCK_EN
        // Pointer only moves once a packet closes.
        if (last_mux_c) begin
          lock_d = 1'b0;
          ptr_d  = SELW'(rr_next(32'(gnt_idx_c), N));
        end else begin
          lock_d   = 1'b1;
          lockid_d = gnt_idx_c;
        end
`else
        ptr_d = SELW'(rr_next(32'(gnt_idx_c), N));
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lockid_q    <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= lock_d;
      lockid_q    <= lockid_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// Scoreboard bench for rr_mux (N=4, WIDTH=8). Follows RR_MUX_LOCK_EN.
module tb_rr_mux;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned SELW = 2;

  logic             clk;
  logic             reset;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     out_data;
  logic [SELW-1:0]  out_sel;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  rr_mux #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           sel;
    logic         last;
  } beat_t;

  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference state: priority start, open-packet flag and owner.
  int    m_ptr    = 0;
  bit    m_lock   = 0;
  int    m_lockid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < int'(N); i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  // One clock of stimulus; predicts in_ready and the accepted beat.
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic ordy, input logic [N*W-1:0] d);
    int           grant;
    bit           load;
    logic [N-1:0] exp_rdy;
    beat_t        b;
    @(negedge clk);
    reset     = r;
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    in_data   = d;
    #1;
    load  = (sb_q.size() == 0) || ordy;
    grant = -1;
    if (!r) begin
      if (m_lock) begin
        if (v[m_lockid]) grant = m_lockid;
      end else begin
        for (int k = 0; k < int'(N); k++) begin
          if (grant < 0 && v[(m_ptr + k) % int'(N)]) grant = (m_ptr + k) % int'(N);
        end
      end
    end
    exp_rdy = (load && grant >= 0) ? (N'(1) << grant) : '0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      sb_q.delete();
      m_ptr  = 0;
      m_lock = 0;
    end else if (load && grant >= 0) begin
      b.d    = d[grant*W +: W];
      b.sel  = grant;
      b.last = l[grant];
      sb_q.push_back(b);
`ifdef RR_MUX_LOCK_EN
      if (l[grant]) begin
        m_lock = 0;
        m_ptr  = (grant + 1) % int'(N);
      end else begin
        m_lock   = 1;
        m_lockid = grant;
      end
`else
      m_ptr = (grant + 1) % int'(N);
`endif
    end
  endtask

  // Monitor: compare the presented beat against the scoreboard head.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0 && out_valid === 1'b1) begin
        chk("out_data", 32'(out_data), 32'(sb_q[0].d));
        chk("out_sel",  32'(out_sel),  32'(sb_q[0].sel));
        chk("out_last", 32'(out_last), 32'(sb_q[0].last));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    reset     = 1'b1;
    in_valid  = 4'b1111;
    in_last   = '1;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset with all inputs valid
    cycle(1'b1, 4'b1111, 4'b1111, 1'b1, rand_data());
    cycle(1'b1, 4'b1111, 4'b1111, 1'b1, rand_data());
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);

    // Single beat from stream 0
    d = rand_data();
    d[W-1:0] = 8'hA5;
    cycle(1'b0, 4'b0001, 4'b1111, 1'b1, d);
    #1;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'hA5);
    chk("single_sel",   32'(out_sel),   32'd0);

    // Wrap: grant 2 moves ptr to 3, then 0001 wraps to 0, then ptr=1 picks 1
    cycle(1'b0, 4'b0100, 4'b1111, 1'b1, rand_data());
    cycle(1'b0, 4'b0001, 4'b1111, 1'b1, rand_data());
    cycle(1'b0, 4'b0011, 4'b1111, 1'b1, rand_data());
    #1;
    chk("wrap_sel", 32'(out_sel), 32'd1);

    // Fairness on two streams
    for (int c = 0; c < 4; c++) cycle(1'b0, 4'b0011, 4'b1111, 1'b1, rand_data());

    // Backpressure then no-bubble reload
    for (int c = 0; c < 3; c++) cycle(1'b0, 4'b0011, 4'b1111, 1'b0, rand_data());
    for (int c = 0; c < 2; c++) cycle(1'b0, 4'b0011, 4'b1111, 1'b1, rand_data());

    // Packet on stream 1 (last on 3rd beat) competing with stream 0
    cycle(1'b0, 4'b0000, 4'b1111, 1'b1, rand_data());
    cycle(1'b0, 4'b0001, 4'b1111, 1'b1, rand_data());
    for (int c = 0; c < 5; c++)
      cycle(1'b0, 4'b0011, {2'b00, 1'(c == 2), 1'b1}, 1'b1, rand_data());

    // Randomized traffic with one mid-run reset
    for (int c = 0; c < 1500; c++) begin
      cycle(1'(c == 700), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0), rand_data());
    end

    // Drain
    for (int c = 0; c < 4; c++) cycle(1'b0, 4'b0000, 4'b0000, 1'b1, rand_data());
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
